// File: rtl/burst_mem_responder.sv
// Line-oriented memory responder for the 64-bit burst side of the cacheline adaptor.
// It takes one 256-bit line request at a time and answers it with four 64-bit beats
// after a programmable latency. Any request-protocol violation sets a sticky flag.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for exactly one of mem_read / mem_write
// S_WAIT  | latency countdown; the read line is buffered on exit
// S_BURST | four beats with mem_resp=1; a write line is committed after beat 3
// S_DONE  | one quiet cycle; request inputs are ignored
module burst_mem_responder #(
   parameter int LATENCY   = 8,
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [63:0] mem_wdata,
   output logic        mem_resp,
   output logic [63:0] mem_rdata,
   output logic        protocol_error
);

   localparam int LINES = 1 << ADDR_BITS;

   // WAIT lasts LATENCY-1 cycles, so the countdown starts at LATENCY-2 and exits on zero.
   // With LATENCY=1 there is no WAIT cycle at all and IDLE goes straight to BURST.
   localparam logic [7:0] WAIT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [7:0]      wait_cnt;
   logic [1:0]      beat;
   logic [1:0]      next_beat;
   logic            op_write;
   logic [26:0]     addr_tag;
   logic [255:0]    rd_buf;
   logic [63:0]     wr_buf [0:3];
   logic [255:0]    line_mem [0:LINES-1];

   logic [ADDR_BITS-1:0] idx_in;
   logic [ADDR_BITS-1:0] line_idx;
   logic                 req_viol;
   logic                 commit;
   logic [255:0]         commit_line;
   logic                 unused_addr_bits;

   // The byte offset within a line does not matter to this responder.
   assign unused_addr_bits = ^mem_address[4:0];

   assign idx_in      = mem_address[ADDR_BITS+4:5];
   assign line_idx    = addr_tag[ADDR_BITS-1:0];
   assign next_beat   = beat + 2'd1;

   // The final beat comes straight from mem_wdata, so the whole line lands in one edge.
   // A reset on that edge suppresses the commit and leaves the old line intact.
   assign commit      = (state == S_BURST) && (beat == 2'd3) && op_write && !rst;
   assign commit_line = {mem_wdata, wr_buf[2], wr_buf[1], wr_buf[0]};

   // A request counts as unstable if the active strobe drops, the opposite strobe rises,
   // or the line address moves away from the one latched at acceptance. The full
   // address[31:5] is compared, so a change in aliased upper bits is a violation as well.
   always_comb begin
      req_viol = 1'b0;
      if (op_write) begin
         req_viol = !mem_write || mem_read;
      end else begin
         req_viol = !mem_read || mem_write;
      end
      if (mem_address[31:5] != addr_tag) begin
         req_viol = 1'b1;
      end
   end

   // Transaction sequencing, beat data and the sticky protocol flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         wait_cnt       <= 8'd0;
         beat           <= 2'd0;
         op_write       <= 1'b0;
         addr_tag       <= 27'd0;
         mem_resp       <= 1'b0;
         mem_rdata      <= 64'd0;
         protocol_error <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               beat <= 2'd0;
               if (mem_read && mem_write) begin
                  protocol_error <= 1'b1;
               end else if (mem_read || mem_write) begin
                  op_write <= mem_write;
                  addr_tag <= mem_address[31:5];
                  wait_cnt <= WAIT_LOAD;
                  if (LATENCY == 1) begin
                     state     <= S_BURST;
                     mem_resp  <= 1'b1;
                     rd_buf    <= line_mem[idx_in];
                     mem_rdata <= mem_write ? 64'd0 : line_mem[idx_in][63:0];
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (req_viol) begin
                  protocol_error <= 1'b1;
               end
               if (wait_cnt == 8'd0) begin
                  state     <= S_BURST;
                  mem_resp  <= 1'b1;
                  rd_buf    <= line_mem[line_idx];
                  mem_rdata <= op_write ? 64'd0 : line_mem[line_idx][63:0];
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end

            S_BURST: begin
               if (req_viol) begin
                  protocol_error <= 1'b1;
               end
               if (op_write) begin
                  wr_buf[beat] <= mem_wdata;
               end
               if (beat == 2'd3) begin
                  state     <= S_DONE;
                  mem_resp  <= 1'b0;
                  mem_rdata <= 64'd0;
               end else begin
                  beat      <= next_beat;
                  mem_rdata <= op_write ? 64'd0 : rd_buf[{next_beat, 6'd0} +: 64];
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Line storage is deliberately not reset so that its contents survive rst.
   always_ff @(posedge clk) begin
      if (commit) begin
         line_mem[line_idx] <= commit_line;
      end
   end

endmodule
